// File: rtl/ram_burst_bus_if.sv
// Control/status bundle between the bus master and ram_burst_bus.
// The shared tristate data bus is a separate inout port so that each side owns its own driver.
interface ram_burst_bus_if #(
    parameter int A = 7,
    parameter int L = 4
);
    logic         act_ram;
    logic         start;
    logic         write_en;
    logic [A-1:0] address_r;
    logic [L-1:0] burst_len;
    logic         wr_strobe;
    logic         rd_valid;
    logic         busy;
    logic         done;
    logic         err;

    modport master (
        output act_ram, start, write_en, address_r, burst_len, wr_strobe,
        input  rd_valid, busy, done, err
    );

    modport slave (
        input  act_ram, start, write_en, address_r, burst_len, wr_strobe,
        output rd_valid, busy, done, err
    );
endinterface

// File: rtl/ram_burst_bus.sv
// Synchronous single-port RAM on a shared bidirectional data bus.
// A clocked controller runs multi-beat bursts with address auto-increment that wraps at N,
// returns registered read data with a valid strobe, and reports done/err as one-cycle pulses.
module ram_burst_bus #(
    parameter int N = 68,
    parameter int M = 8,
    parameter int A = 7,
    parameter int L = 4
) (
    input  logic           clk1,
    input  logic           rst_n,
    ram_burst_bus_if.slave bus,
    inout  wire  [M-1:0]   data
);
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

    // N widened by one bit so the range check also works when N == 2**A
    localparam logic [A:0] LP_N    = (A+1)'(N);
    localparam logic [A-1:0] LP_LAST = A'(N - 1);

    state_t       r_state;
    state_t       w_next_state;
    logic [A-1:0] r_addr;
    logic [L-1:0] r_cnt;
    logic         r_rd_valid;
    logic         r_err;
    logic [M-1:0] r_data_q;
    logic [M-1:0] r_mem [N];

    logic         w_start_req;
    logic         w_bad_start;
    logic         w_accept;
    logic         w_abort;
    logic         w_wr_beat;
    logic         w_rd_beat;
    logic [A-1:0] w_addr_next;

    // Start decode: only honoured in IDLE with chip select high
    assign w_start_req = (r_state == S_IDLE) && bus.start && bus.act_ram;
    assign w_bad_start = w_start_req && ({1'b0, bus.address_r} >= LP_N);
    assign w_accept    = w_start_req && !w_bad_start;

    // Burst address advances through 0..N-1 and wraps at N, not at 2**A
    assign w_addr_next = (r_addr == LP_LAST) ? '0 : r_addr + A'(1);

    // State register
    // NOTE: clocked state uses non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    // NOTE: combinational blocks assign a default first, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = bus.write_en ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                if (w_abort) begin
                    w_next_state = S_IDLE;
                end else if (w_wr_beat && (r_cnt == '0)) begin
                    w_next_state = S_DONE;
                end
            end
            S_READ: begin
                if (w_abort) begin
                    w_next_state = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_next_state = S_DONE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output and per-cycle control decode
    always_comb begin
        w_abort   = 1'b0;
        w_wr_beat = 1'b0;
        w_rd_beat = 1'b0;
        bus.busy  = (r_state != S_IDLE);
        bus.done  = (r_state == S_DONE);
        case (r_state)
            S_WRITE: begin
                w_abort   = !bus.act_ram;
                w_wr_beat = bus.act_ram && bus.wr_strobe;
            end
            S_READ: begin
                w_abort   = !bus.act_ram;
                w_rd_beat = bus.act_ram;
            end
            default: ;
        endcase
    end

    // Burst address/count and status strobes; rd_valid follows the read beat one edge later
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_cnt      <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err      <= w_bad_start || w_abort;
            r_rd_valid <= w_rd_beat;
            if (w_accept) begin
                r_addr <= bus.address_r;
                r_cnt  <= bus.burst_len;
            end else if (w_wr_beat || w_rd_beat) begin
                r_addr <= w_addr_next;
                r_cnt  <= r_cnt - L'(1);
            end
        end
    end

    // Storage array and registered read data
    // NOTE: the array is deliberately not reset, so a burst cut by reset keeps the beats already written.
    always_ff @(posedge clk1) begin
        if (w_wr_beat) begin
            r_mem[r_addr] <= data;
        end
        if (w_rd_beat) begin
            r_data_q <= r_mem[r_addr];
        end
    end

    assign bus.rd_valid = r_rd_valid;
    assign bus.err      = r_err;

    // Drive the shared bus only while presenting a read beat to a selected master
    assign data = (r_rd_valid && bus.act_ram) ? r_data_q : 'z;
endmodule

// File: tb/tb_ram_burst_bus.sv
// Self-checking bench for ram_burst_bus: directed scenarios plus randomized bursts
// checked against an array model indexed with modulo-N address arithmetic.
module tb_ram_burst_bus;
    localparam int N = 68;
    localparam int M = 8;
    localparam int A = 7;
    localparam int L = 4;

    logic         clk1 = 1'b0;
    logic         rst_n = 1'b0;
    wire  [M-1:0] data;
    logic [M-1:0] tb_drv;
    logic         tb_oe;

    assign data = tb_oe ? tb_drv : 'z;

    ram_burst_bus_if #(.A(A), .L(L)) bus ();

    ram_burst_bus #(.N(N), .M(M), .A(A), .L(L)) dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .bus   (bus),
        .data  (data)
    );

    always #5 clk1 = ~clk1;

    int checks = 0;
    int errors = 0;
    logic [M-1:0] ref_mem [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Write burst. data_base<0 gives random data, pattern<0 gives random stalls,
    // abort_k>=0 drops act_ram after abort_k beats. Entered and left at a falling edge.
    task automatic do_write(input int addr, input int len, input int data_base,
                            input int pattern, input int abort_k, output int ncyc);
        int a;
        int beats;
        logic strobe;
        logic [M-1:0] d;
        ncyc = 0;
        bus.act_ram   = 1'b1;
        bus.start     = 1'b1;
        bus.write_en  = 1'b1;
        bus.address_r = A'(addr);
        bus.burst_len = L'(len);
        bus.wr_strobe = 1'b0;
        tb_oe         = 1'b0;
        @(negedge clk1);
        bus.start = 1'b0;
        if (addr >= N) begin
            check("wr_bad_err", 32'(bus.err), 1);
            check("wr_bad_busy", 32'(bus.busy), 0);
            @(negedge clk1);
            check("wr_bad_err_pulse", 32'(bus.err), 0);
            check("wr_bad_idle", 32'(bus.busy), 0);
            return;
        end
        check("wr_busy", 32'(bus.busy), 1);
        check("wr_err", 32'(bus.err), 0);
        check("wr_done_early", 32'(bus.done), 0);
        a = addr;
        beats = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (abort_k >= 0 && beats == abort_k) begin
                bus.act_ram   = 1'b0;
                bus.start     = 1'b0;
                bus.wr_strobe = 1'b1;
                tb_oe         = 1'b1;
                tb_drv        = M'($urandom);
                @(negedge clk1);
                bus.wr_strobe = 1'b0;
                tb_oe         = 1'b0;
                check("wr_abort_err", 32'(bus.err), 1);
                check("wr_abort_busy", 32'(bus.busy), 0);
                check("wr_abort_done", 32'(bus.done), 0);
                return;
            end
            strobe = (pattern >= 0) ? pattern[cyc] : ($urandom_range(0, 3) != 0);
            d = (data_base >= 0) ? M'(data_base + beats) : M'($urandom);
            bus.wr_strobe = strobe;
            tb_oe         = strobe;
            tb_drv        = d;
            bus.start     = ($urandom_range(0, 3) == 0);
            bus.address_r = A'($urandom);
            @(negedge clk1);
            ncyc = cyc + 1;
            if (strobe) begin
                check("wr_bus_own", 32'(data), 32'(d));
                ref_mem[a] = d;
                a = (a + 1) % N;
                beats++;
            end
            check("wr_rd_valid", 32'(bus.rd_valid), 0);
            if (beats == len + 1) begin
                check("wr_done", 32'(bus.done), 1);
                check("wr_busy_in_done", 32'(bus.busy), 1);
                bus.wr_strobe = 1'b0;
                tb_oe         = 1'b0;
                bus.start     = 1'b0;
                @(negedge clk1);
                check("wr_done_pulse", 32'(bus.done), 0);
                check("wr_idle", 32'(bus.busy), 0);
                return;
            end
            check("wr_no_done", 32'(bus.done), 0);
            check("wr_busy_mid", 32'(bus.busy), 1);
        end
        check("wr_beats_budget", 32'(beats), 32'(len + 1));
    endtask

    // Read burst; abort_k>=0 drops act_ram after abort_k beats were returned.
    task automatic do_read(input int addr, input int len, input int abort_k);
        int a;
        bus.act_ram   = 1'b1;
        bus.start     = 1'b1;
        bus.write_en  = 1'b0;
        bus.address_r = A'(addr);
        bus.burst_len = L'(len);
        bus.wr_strobe = 1'b0;
        tb_oe         = 1'b0;
        @(negedge clk1);
        bus.start = 1'b0;
        if (addr >= N) begin
            check("rd_bad_err", 32'(bus.err), 1);
            check("rd_bad_busy", 32'(bus.busy), 0);
            check("rd_bad_valid", 32'(bus.rd_valid), 0);
            @(negedge clk1);
            check("rd_bad_err_pulse", 32'(bus.err), 0);
            return;
        end
        check("rd_busy", 32'(bus.busy), 1);
        check("rd_err", 32'(bus.err), 0);
        check("rd_valid_latency", 32'(bus.rd_valid), 0);
        a = addr;
        for (int i = 0; i <= len; i++) begin
            if (abort_k == i) begin
                bus.act_ram = 1'b0;
                bus.start   = 1'b0;
                @(negedge clk1);
                check("rd_abort_err", 32'(bus.err), 1);
                check("rd_abort_valid", 32'(bus.rd_valid), 0);
                check("rd_abort_busy", 32'(bus.busy), 0);
                check("rd_abort_done", 32'(bus.done), 0);
                tb_oe  = 1'b1;
                tb_drv = 8'h5A;
                #1;
                check("rd_abort_bus_free", 32'(data), 32'h5A);
                tb_oe  = 1'b0;
                return;
            end
            bus.start     = ($urandom_range(0, 3) == 0);
            bus.address_r = A'($urandom);
            @(negedge clk1);
            check("rd_valid", 32'(bus.rd_valid), 1);
            check("rd_data", 32'(data), 32'(ref_mem[a]));
            check("rd_done", 32'(bus.done), (i == len) ? 1 : 0);
            a = (a + 1) % N;
        end
        bus.start = 1'b0;
        @(negedge clk1);
        check("rd_valid_end", 32'(bus.rd_valid), 0);
        check("rd_done_pulse", 32'(bus.done), 0);
        check("rd_idle", 32'(bus.busy), 0);
    endtask

    // Asynchronous reset a few ns after a falling edge, checked before the next rising edge.
    task automatic reset_mid_cycle();
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_rd_valid", 32'(bus.rd_valid), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_err", 32'(bus.err), 0);
        tb_oe  = 1'b1;
        tb_drv = 8'h3C;
        #1;
        check("rst_bus_free", 32'(data), 32'h3C);
        tb_oe         = 1'b0;
        bus.start     = 1'b0;
        bus.wr_strobe = 1'b0;
        @(negedge clk1);
        rst_n = 1'b1;
        @(negedge clk1);
        check("rst_release_idle", 32'(bus.busy), 0);
        check("rst_release_valid", 32'(bus.rd_valid), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ncyc;
        int addr;
        int len;
        int ab;
        bus.act_ram   = 1'b0;
        bus.start     = 1'b0;
        bus.write_en  = 1'b0;
        bus.address_r = '0;
        bus.burst_len = '0;
        bus.wr_strobe = 1'b0;
        tb_oe         = 1'b0;
        tb_drv        = '0;
        #1;
        check("init_busy", 32'(bus.busy), 0);
        check("init_rd_valid", 32'(bus.rd_valid), 0);
        check("init_done", 32'(bus.done), 0);
        check("init_err", 32'(bus.err), 0);
        @(negedge clk1);
        rst_n = 1'b1;
        @(negedge clk1);

        // Preload every location so all later reads have a known expectation
        for (int b = 0; b < N; b += 16) begin
            do_write(b, (N - b > 16) ? 15 : N - b - 1, -1, -1, -1, ncyc);
        end

        // Single write and read back
        do_write(5, 0, 8'hA5, 1, -1, ncyc);
        do_read(5, 0, -1);

        // Burst wrapping past N-1
        do_write(66, 3, 1, 'hFFFF, -1, ncyc);
        do_read(66, 3, -1);

        // Stalled write: strobe pattern 1,0,0,1
        do_write(30, 1, -1, 'b1001, -1, ncyc);
        check("stall_cycles", 32'(ncyc), 4);
        do_read(29, 3, -1);

        // Bad start address, then confirm memory untouched
        do_write(70, 2, -1, -1, -1, ncyc);
        do_read(70, 0, -1);
        do_read(0, 15, -1);

        // Read abort after the third beat, immediately followed by a new start
        do_read(0, 7, 3);
        do_read(0, 0, -1);

        // Reset mid write burst: three beats land, the fourth does not
        bus.act_ram   = 1'b1;
        bus.start     = 1'b1;
        bus.write_en  = 1'b1;
        bus.address_r = A'(20);
        bus.burst_len = L'(7);
        @(negedge clk1);
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.wr_strobe = 1'b1;
            tb_oe         = 1'b1;
            tb_drv        = M'($urandom);
            @(negedge clk1);
            ref_mem[20 + i] = tb_drv;
        end
        tb_drv = M'($urandom);
        reset_mid_cycle();
        do_read(18, 7, -1);

        // Reset mid read burst
        bus.act_ram   = 1'b1;
        bus.start     = 1'b1;
        bus.write_en  = 1'b0;
        bus.address_r = A'(40);
        bus.burst_len = L'(7);
        @(negedge clk1);
        bus.start = 1'b0;
        @(negedge clk1);
        @(negedge clk1);
        check("rst_rd_active", 32'(bus.rd_valid), 1);
        reset_mid_cycle();

        // Randomized traffic
        for (int t = 0; t < 150; t++) begin
            addr = $urandom_range(0, 79);
            len  = $urandom_range(0, 15);
            ab   = -1;
            if ($urandom_range(0, 7) == 0) begin
                ab = $urandom_range(0, len);
            end
            if ($urandom_range(0, 1) == 1) begin
                do_write(addr, len, -1, -1, ab, ncyc);
            end else begin
                do_read(addr, len, ab);
            end
        end

        // Full readback
        for (int b = 0; b < N; b += 16) begin
            do_read(b, (N - b > 16) ? 15 : N - b - 1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
